// File: rtl/fmul_pkg.sv
// Shared class codes and width helper for the floating-point multiplier front end.
package fmul_pkg;

    localparam logic [4:0] CLS_NAN    = 5'd0;
    localparam logic [4:0] CLS_ZERO   = 5'd1;
    localparam logic [4:0] CLS_NORM   = 5'd2;
    localparam logic [4:0] CLS_DENORM = 5'd3;
    localparam logic [4:0] CLS_INF    = 5'd4;

    function automatic int unsigned op_width(input int unsigned exp_w, input int unsigned man_w);
        return 1 + exp_w + man_w;
    endfunction

endpackage

// File: rtl/fp_op_class.sv
// Classifies one IEEE-style operand and counts leading zeros of its fraction.
module fp_op_class
    import fmul_pkg::*;
#(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23,
    parameter int unsigned LZC_W = $clog2(MAN_W + 1)
) (
    input  logic [EXP_W-1:0] exp_f,
    input  logic [MAN_W-1:0] frac,
    output logic [4:0]       cls_c,
    output logic [LZC_W-1:0] lzc_c
);

    logic exp_ones;
    logic exp_zero;
    logic frac_zero;

    assign exp_ones  = &exp_f;
    assign exp_zero  = ~|exp_f;
    assign frac_zero = ~|frac;

    always_comb begin
        cls_c = CLS_NORM;
        if (exp_ones) begin
            cls_c = frac_zero ? CLS_INF : CLS_NAN;
        end else if (exp_zero) begin
            cls_c = frac_zero ? CLS_ZERO : CLS_DENORM;
        end
    end

    // Ascending scan: the highest set bit is written last and wins.
    always_comb begin
        lzc_c = '0;
        for (int i = 0; i < MAN_W; i++) begin
            if (frac[i]) begin
                lzc_c = LZC_W'(MAN_W - 1 - i);
            end
        end
    end

endmodule

// File: rtl/fmul_op_unpack.sv
// Two-stage operand unpacker: classify, normalise denormals, predict special
// results and count special-case pairs.
module fmul_op_unpack
    import fmul_pkg::*;
#(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23,
    parameter int unsigned CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [EXP_W+MAN_W:0] in_a,
    input  logic [EXP_W+MAN_W:0] in_b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               a_sign,
    output logic               b_sign,
    output logic [4:0]         a_class,
    output logic [4:0]         b_class,
    output logic [EXP_W+1:0]   a_exp,
    output logic [EXP_W+1:0]   b_exp,
    output logic [MAN_W:0]     a_mant,
    output logic [MAN_W:0]     b_mant,
    output logic               res_nan,
    output logic               res_inf,
    output logic               res_zero,
    output logic               res_sign,
    output logic [CNT_W-1:0]   spec_cnt,
    input  logic               cnt_clr
);

    localparam int unsigned OP_W  = op_width(EXP_W, MAN_W);
    localparam int unsigned LZC_W = $clog2(MAN_W + 1);
    localparam int unsigned XE_W  = EXP_W + 2;

    logic              ready1_c;
    logic              ready2_c;
    logic [4:0]        a_cls_c;
    logic [4:0]        b_cls_c;
    logic [LZC_W-1:0]  a_lzc_c;
    logic [LZC_W-1:0]  b_lzc_c;

    logic              v1;
    logic [OP_W-1:0]   a1;
    logic [OP_W-1:0]   b1;
    logic [4:0]        a1_cls;
    logic [4:0]        b1_cls;
    logic [LZC_W-1:0]  a1_lzc;
    logic [LZC_W-1:0]  b1_lzc;

    logic              nan_c;
    logic              inf_c;
    logic              zero_c;

    assign ready2_c = !out_valid || out_ready;
    assign ready1_c = !v1 || ready2_c;
    assign in_ready = ready1_c;

    fp_op_class #(.EXP_W(EXP_W), .MAN_W(MAN_W), .LZC_W(LZC_W)) u_cls_a (
        .exp_f (in_a[OP_W-2 -: EXP_W]),
        .frac  (in_a[MAN_W-1:0]),
        .cls_c (a_cls_c),
        .lzc_c (a_lzc_c)
    );

    fp_op_class #(.EXP_W(EXP_W), .MAN_W(MAN_W), .LZC_W(LZC_W)) u_cls_b (
        .exp_f (in_b[OP_W-2 -: EXP_W]),
        .frac  (in_b[MAN_W-1:0]),
        .cls_c (b_cls_c),
        .lzc_c (b_lzc_c)
    );

    function automatic logic [MAN_W:0] unpack_mant(input logic [OP_W-1:0] op,
                                                   input logic [4:0] cls,
                                                   input logic [LZC_W-1:0] lzc);
        logic [MAN_W:0] m;
        m = {1'b0, op[MAN_W-1:0]};
        case (cls)
            CLS_NORM:   m = {1'b1, op[MAN_W-1:0]};
            CLS_DENORM: m = {op[MAN_W-1:0], 1'b0} << lzc;
            CLS_ZERO:   m = '0;
            default:    ;
        endcase
        return m;
    endfunction

    function automatic logic [XE_W-1:0] unpack_exp(input logic [OP_W-1:0] op,
                                                   input logic [4:0] cls,
                                                   input logic [LZC_W-1:0] lzc);
        logic [XE_W-1:0] e;
        e = XE_W'(op[OP_W-2 -: EXP_W]);
        case (cls)
            CLS_DENORM: e = XE_W'(0) - XE_W'(lzc);
            CLS_ZERO:   e = '0;
            default:    ;
        endcase
        return e;
    endfunction

    // Special-result prediction from the stage-1 classes.
    always_comb begin
        nan_c  = (a1_cls == CLS_NAN) || (b1_cls == CLS_NAN)
              || ((a1_cls == CLS_ZERO) && (b1_cls == CLS_INF))
              || ((a1_cls == CLS_INF) && (b1_cls == CLS_ZERO));
        inf_c  = ((a1_cls == CLS_INF) || (b1_cls == CLS_INF)) && !nan_c;
        zero_c = ((a1_cls == CLS_ZERO) || (b1_cls == CLS_ZERO)) && !nan_c;
    end

    // Stage 1: raw operands, class and leading-zero count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1     <= 1'b0;
            a1     <= '0;
            b1     <= '0;
            a1_cls <= '0;
            b1_cls <= '0;
            a1_lzc <= '0;
            b1_lzc <= '0;
        end else if (ready1_c) begin
            v1 <= in_valid;
            if (in_valid) begin
                a1     <= in_a;
                b1     <= in_b;
                a1_cls <= a_cls_c;
                b1_cls <= b_cls_c;
                a1_lzc <= a_lzc_c;
                b1_lzc <= b_lzc_c;
            end
        end
    end

    // Stage 2: normalised mantissas, exponents and predictions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            a_sign    <= 1'b0;
            b_sign    <= 1'b0;
            a_class   <= '0;
            b_class   <= '0;
            a_exp     <= '0;
            b_exp     <= '0;
            a_mant    <= '0;
            b_mant    <= '0;
            res_nan   <= 1'b0;
            res_inf   <= 1'b0;
            res_zero  <= 1'b0;
            res_sign  <= 1'b0;
        end else if (ready2_c) begin
            out_valid <= v1;
            if (v1) begin
                a_sign   <= a1[OP_W-1];
                b_sign   <= b1[OP_W-1];
                a_class  <= a1_cls;
                b_class  <= b1_cls;
                a_exp    <= unpack_exp(a1, a1_cls, a1_lzc);
                b_exp    <= unpack_exp(b1, b1_cls, b1_lzc);
                a_mant   <= unpack_mant(a1, a1_cls, a1_lzc);
                b_mant   <= unpack_mant(b1, b1_cls, b1_lzc);
                res_nan  <= nan_c;
                res_inf  <= inf_c;
                res_zero <= zero_c;
                res_sign <= a1[OP_W-1] ^ b1[OP_W-1];
            end
        end
    end

    // Saturating special-pair counter; clear wins over increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spec_cnt <= '0;
        end else if (cnt_clr) begin
            spec_cnt <= '0;
        end else if (out_valid && out_ready && (res_nan || res_inf || res_zero)
                     && (spec_cnt != '1)) begin
            spec_cnt <= spec_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_fmul_op_unpack.sv
// Scoreboard bench for fmul_op_unpack: directed operand pairs with hand-computed results.
module tb_fmul_op_unpack;
    import fmul_pkg::*;

    localparam int unsigned EXP_W = 8;
    localparam int unsigned MAN_W = 23;
    localparam int unsigned CNT_W = 2;

    typedef struct packed {
        logic             a_sign;
        logic             b_sign;
        logic [4:0]       a_class;
        logic [4:0]       b_class;
        logic [EXP_W+1:0] a_exp;
        logic [EXP_W+1:0] b_exp;
        logic [MAN_W:0]   a_mant;
        logic [MAN_W:0]   b_mant;
        logic             res_nan;
        logic             res_inf;
        logic             res_zero;
        logic             res_sign;
    } resp_t;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        resp_t       r;
    } vec_t;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_a;
    logic [31:0]      in_b;
    logic             out_valid;
    logic             out_ready;
    logic             a_sign, b_sign;
    logic [4:0]       a_class, b_class;
    logic [EXP_W+1:0] a_exp, b_exp;
    logic [MAN_W:0]   a_mant, b_mant;
    logic             res_nan, res_inf, res_zero, res_sign;
    logic [CNT_W-1:0] spec_cnt;
    logic             cnt_clr;

    fmul_op_unpack #(.EXP_W(EXP_W), .MAN_W(MAN_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .a_sign    (a_sign),
        .b_sign    (b_sign),
        .a_class   (a_class),
        .b_class   (b_class),
        .a_exp     (a_exp),
        .b_exp     (b_exp),
        .a_mant    (a_mant),
        .b_mant    (b_mant),
        .res_nan   (res_nan),
        .res_inf   (res_inf),
        .res_zero  (res_zero),
        .res_sign  (res_sign),
        .spec_cnt  (spec_cnt),
        .cnt_clr   (cnt_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          n_sent = 0;
    int          n_recv = 0;
    int          base;
    int          cnt_model = 0;
    resp_t       scb[$];
    vec_t        vecs[12];
    resp_t       got;
    resp_t       e;
    logic [84:0] snap;
    logic        stall_prev = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    function automatic resp_t r(input logic as, input logic bs, input logic [4:0] ac,
                                input logic [4:0] bc, input logic [9:0] ae, input logic [9:0] be,
                                input logic [23:0] am, input logic [23:0] bm, input logic [3:0] f);
        return {as, bs, ac, bc, ae, be, am, bm, f};
    endfunction

    // Drive one pair (inputs change at posedge+1) and record it once accepted.
    task automatic send(input vec_t v);
        int  n = 0;
        bit  done = 0;
        in_a = v.a;
        in_b = v.b;
        in_valid = 1'b1;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                scb.push_back(v.r);
                n_sent++;
                done = 1;
            end else if (n > 50) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: in_ready stuck at %0b required 1", in_ready);
                done = 1;
            end
            n++;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (scb.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain_empty", 128'(scb.size()), 128'd0);
    endtask

    // Monitor: pop and compare on every output transfer, track spec_cnt and stall stability.
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_prev = 1'b0;
        end else begin
            got = {a_sign, b_sign, a_class, b_class, a_exp, b_exp, a_mant, b_mant,
                   res_nan, res_inf, res_zero, res_sign};
            if (stall_prev) chk("stall_stable", 128'({out_valid, got}), 128'(snap));
            chk("spec_cnt", 128'(spec_cnt), 128'(cnt_model));
            if (cnt_clr) cnt_model = 0;
            if (out_valid && out_ready) begin
                n_recv++;
                if (scb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got %h expected none", got);
                end else begin
                    e = scb.pop_front();
                    chk("out_data", 128'(got), 128'(e));
                    if (!cnt_clr && (e.res_nan || e.res_inf || e.res_zero) && cnt_model < 3)
                        cnt_model++;
                end
            end
            stall_prev = out_valid && !out_ready;
            snap = {out_valid, got};
        end
    end

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_a = '0;
        in_b = '0;
        out_ready = 1'b1;
        cnt_clr = 1'b0;

        vecs[0]  = {32'h3F800000, 32'h40000000, r(0, 0, CLS_NORM, CLS_NORM, 10'd127, 10'd128, 24'h800000, 24'h800000, 4'b0000)};
        vecs[1]  = {32'h00000001, 32'h00400000, r(0, 0, CLS_DENORM, CLS_DENORM, 10'h3EA, 10'd0, 24'h800000, 24'h800000, 4'b0000)};
        vecs[2]  = {32'h7F800000, 32'h80000000, r(0, 1, CLS_INF, CLS_ZERO, 10'd255, 10'd0, 24'h000000, 24'h000000, 4'b1001)};
        vecs[3]  = {32'h7FC00000, 32'h3F800000, r(0, 0, CLS_NAN, CLS_NORM, 10'd255, 10'd127, 24'h400000, 24'h800000, 4'b1000)};
        vecs[4]  = {32'hFF800000, 32'h3F800000, r(1, 0, CLS_INF, CLS_NORM, 10'd255, 10'd127, 24'h000000, 24'h800000, 4'b0101)};
        vecs[5]  = {32'h00000000, 32'hBF800000, r(0, 1, CLS_ZERO, CLS_NORM, 10'd0, 10'd127, 24'h000000, 24'h800000, 4'b0011)};
        vecs[6]  = {32'h7F800000, 32'h7F800001, r(0, 0, CLS_INF, CLS_NAN, 10'd255, 10'd255, 24'h000000, 24'h000001, 4'b1000)};
        vecs[7]  = {32'h40490FDB, 32'hC0000000, r(0, 1, CLS_NORM, CLS_NORM, 10'd128, 10'd128, 24'hC90FDB, 24'h800000, 4'b0001)};
        vecs[8]  = {32'h007FFFFF, 32'h00000000, r(0, 0, CLS_DENORM, CLS_ZERO, 10'd0, 10'd0, 24'hFFFFFE, 24'h000000, 4'b0010)};
        vecs[9]  = {32'h00000002, 32'h7F7FFFFF, r(0, 0, CLS_DENORM, CLS_NORM, 10'h3EB, 10'd254, 24'h800000, 24'hFFFFFF, 4'b0000)};
        vecs[10] = {32'h80000000, 32'hFF800000, r(1, 1, CLS_ZERO, CLS_INF, 10'd0, 10'd255, 24'h000000, 24'h000000, 4'b1000)};
        vecs[11] = {32'h00000003, 32'h80000001, r(0, 1, CLS_DENORM, CLS_DENORM, 10'h3EB, 10'h3EA, 24'hC00000, 24'h800000, 4'b0001)};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 128'(out_valid), 128'd0);
        chk("rst_data", 128'({a_sign, b_sign, a_class, b_class, a_exp, b_exp, a_mant, b_mant,
                              res_nan, res_inf, res_zero, res_sign}), 128'd0);
        chk("rst_spec_cnt", 128'(spec_cnt), 128'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 128'(in_ready), 128'd1);
        @(posedge clk);
        #1;

        // Back-to-back directed vectors; seven specials saturate the 2-bit counter.
        for (int i = 0; i < 12; i++) send(vecs[i]);
        drain();

        // Backpressure: two pairs fill the pipe, then in_ready must fall.
        out_ready = 1'b0;
        base = n_sent;
        fork
            begin
                for (int i = 0; i < 8; i++) send(vecs[i]);
            end
            begin
                repeat (4) @(posedge clk);
                #1;
                chk("stall_in_ready", 128'(in_ready), 128'd0);
                chk("stall_accepted", 128'(n_sent - base), 128'd2);
                out_ready = 1'b1;
            end
        join
        drain();

        // cnt_clr held while special pairs transfer.
        fork
            begin
                send(vecs[2]); send(vecs[3]); send(vecs[4]);
                send(vecs[5]); send(vecs[6]); send(vecs[10]);
            end
            begin
                repeat (4) @(posedge clk);
                #1;
                cnt_clr = 1'b1;
                repeat (2) @(posedge clk);
                #1;
                cnt_clr = 1'b0;
            end
        join
        drain();
        chk("cnt_after_clr", 128'(spec_cnt), 128'd2);

        // Reset with pairs in flight drops them.
        send(vecs[0]);
        send(vecs[2]);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 128'(out_valid), 128'd0);
        chk("midrst_spec_cnt", 128'(spec_cnt), 128'd0);
        n_sent -= scb.size();
        scb.delete();
        cnt_model = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", 128'(in_ready), 128'd1);
        @(posedge clk);
        #1;
        send(vecs[7]);
        send(vecs[10]);
        drain();
        chk("delivered_count", 128'(n_recv), 128'(n_sent));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
